// File: rtl/alu_instr_sequencer_if.sv
// Strobe/handshake bundle between the ALU instruction sequencer and the DataPath.
interface alu_instr_sequencer_if #(
  parameter int unsigned NREG = 16,
  parameter int unsigned OPW  = 4
);
  logic [31:0]     IR;
  logic            Mem_ready;
  logic            PCout;
  logic            Zlowout;
  logic            Zhighout;
  logic            MDRout;
  logic            MARin;
  logic            PCin;
  logic            MDRin;
  logic            IRin;
  logic            Yin;
  logic            Zin_low;
  logic            Zin_high;
  logic            HIin;
  logic            LOin;
  logic            IncPC;
  logic            Read;
  logic [NREG-1:0] Rout;
  logic [NREG-1:0] Rin;
  logic [OPW-1:0]  operation;
  logic            Run;
  logic            Illegal;

  modport master (
    output IR, Mem_ready,
    input  PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin,
           Zin_low, Zin_high, HIin, LOin, IncPC, Read, Rout, Rin, operation,
           Run, Illegal
  );

  modport slave (
    input  IR, Mem_ready,
    output PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin,
           Zin_low, Zin_high, HIin, LOin, IncPC, Read, Rout, Rin, operation,
           Run, Illegal
  );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Fetch/execute control sequencer for register-register ALU instructions.
// Strobes are decoded combinationally from the current step and the IR.
module alu_instr_sequencer #(
  parameter int unsigned NREG = 16,
  parameter int unsigned OPW  = 4
) (
  input  logic                   Clock,
  input  logic                   clear,
  alu_instr_sequencer_if.slave   bus
);

  localparam int unsigned OPC_W = 5;
  localparam int unsigned RID_W = 4;

  localparam logic [OPC_W-1:0] OPC_AND  = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_SHR  = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_SHL  = 5'b00111;
  localparam logic [OPC_W-1:0] OPC_ROL  = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_ROR  = 5'b01001;
  localparam logic [OPC_W-1:0] OPC_MUL  = 5'b01010;
  localparam logic [OPC_W-1:0] OPC_DIV  = 5'b01011;
  localparam logic [OPC_W-1:0] OPC_NEG  = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_NOT  = 5'b01101;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11000;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11001;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T1W, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_muldiv;

  logic [OPC_W-1:0] w_opc;
  logic [RID_W-1:0] w_ra, w_rb, w_rc;
  logic [NREG-1:0]  w_ra_oh, w_rb_oh, w_rc_oh;
  logic [OPW-1:0]   w_op;
  logic             w_alu, w_unary, w_muldiv, w_illegal;
  logic             w_unused_ir;

  assign w_opc       = bus.IR[31:27];
  assign w_ra        = bus.IR[26:23];
  assign w_rb        = bus.IR[22:19];
  assign w_rc        = bus.IR[18:15];
  assign w_unused_ir = ^bus.IR[14:0];
  assign w_ra_oh     = NREG'(1) << w_ra;
  assign w_rb_oh     = NREG'(1) << w_rb;
  assign w_rc_oh     = NREG'(1) << w_rc;
  assign w_illegal   = !w_alu && (w_opc != OPC_NOP) && (w_opc != OPC_HALT);

  // Opcode to ALU function and instruction class
  always_comb begin
    w_op     = '0;
    w_alu    = 1'b1;
    w_unary  = 1'b0;
    w_muldiv = 1'b0;
    case (w_opc)
      OPC_AND: w_op = OPW'(4'b0010);
      OPC_ADD: w_op = OPW'(4'b0000);
      OPC_SUB: w_op = OPW'(4'b0001);
      OPC_OR:  w_op = OPW'(4'b0011);
      OPC_SHR: w_op = OPW'(4'b0100);
      OPC_SHL: w_op = OPW'(4'b0101);
      OPC_ROL: w_op = OPW'(4'b0110);
      OPC_ROR: w_op = OPW'(4'b0111);
      OPC_MUL: begin w_op = OPW'(4'b1000); w_muldiv = 1'b1; end
      OPC_DIV: begin w_op = OPW'(4'b1001); w_muldiv = 1'b1; end
      OPC_NEG: begin w_op = OPW'(4'b1010); w_unary  = 1'b1; end
      OPC_NOT: begin w_op = OPW'(4'b1011); w_unary  = 1'b1; end
      default: w_alu = 1'b0;
    endcase
  end

  // Step register; the mul/div class is captured in T3 so the T5 branch ignores later IR changes
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_state  <= ST_RST;
      r_muldiv <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_T3) r_muldiv <= w_muldiv;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RST:  w_next = ST_T0;
      ST_T0:   w_next = ST_T1;
      ST_T1:   w_next = bus.Mem_ready ? ST_T2 : ST_T1W;
      ST_T1W:  w_next = bus.Mem_ready ? ST_T2 : ST_T1W;
      ST_T2:   w_next = ST_T3;
      ST_T3: begin
        if (w_alu)                  w_next = ST_T4;
        else if (w_opc == OPC_HALT) w_next = ST_HALT;
        else                        w_next = ST_T0;
      end
      ST_T4:   w_next = ST_T5;
      ST_T5:   w_next = r_muldiv ? ST_T6 : ST_T0;
      ST_T6:   w_next = ST_T0;
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_RST;
    endcase
  end

  // Per-step strobe decode
  always_comb begin
    bus.PCout     = 1'b0;
    bus.Zlowout   = 1'b0;
    bus.Zhighout  = 1'b0;
    bus.MDRout    = 1'b0;
    bus.MARin     = 1'b0;
    bus.PCin      = 1'b0;
    bus.MDRin     = 1'b0;
    bus.IRin      = 1'b0;
    bus.Yin       = 1'b0;
    bus.Zin_low   = 1'b0;
    bus.Zin_high  = 1'b0;
    bus.HIin      = 1'b0;
    bus.LOin      = 1'b0;
    bus.IncPC     = 1'b0;
    bus.Read      = 1'b0;
    bus.Rout      = '0;
    bus.Rin       = '0;
    bus.operation = '0;
    bus.Illegal   = 1'b0;
    bus.Run       = (r_state != ST_RST) && (r_state != ST_HALT);
    case (r_state)
      ST_T0: begin
        bus.PCout   = 1'b1;
        bus.MARin   = 1'b1;
        bus.IncPC   = 1'b1;
        bus.Zin_low = 1'b1;
      end
      ST_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      ST_T1W: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
      end
      ST_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      ST_T3: begin
        if (w_alu) begin
          bus.Rout = w_rb_oh;
          bus.Yin  = 1'b1;
        end
        bus.Illegal = w_illegal;
      end
      ST_T4: begin
        if (w_alu) begin
          bus.Rout      = w_unary ? w_rb_oh : w_rc_oh;
          bus.operation = w_op;
          bus.Zin_low   = 1'b1;
          bus.Zin_high  = w_muldiv;
        end
      end
      ST_T5: begin
        if (w_alu) begin
          bus.Zlowout = 1'b1;
          if (w_muldiv) bus.LOin = 1'b1;
          else          bus.Rin  = w_ra_oh;
        end
      end
      ST_T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
